// File: rtl/flash_reader_pkg.sv
// Shared opcodes, field sizes and FSM state type for spi_flash_reader.
// FLASH_FAST_READ_EN selects FAST READ (0x0B + dummy byte) instead of READ (0x03).
package flash_reader_pkg;

  localparam logic [7:0]  OPC_READ      = 8'h03;
  localparam logic [7:0]  OPC_FAST_READ = 8'h0B;
  localparam int unsigned DUMMY_BITS    = 8;
  localparam int unsigned CMD_BITS      = 8;
  localparam int unsigned ADDR_BITS     = 24;

`ifdef FLASH_FAST_READ_EN
  localparam logic [7:0] OPCODE = OPC_FAST_READ;
  typedef enum logic [2:0] {
    ST_IDLE, ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA, ST_END
  } state_e;
`else
  localparam logic [7:0] OPCODE = OPC_READ;
  typedef enum logic [2:0] {
    ST_IDLE, ST_CMD, ST_ADDR, ST_DATA, ST_END
  } state_e;
`endif

endpackage

// File: rtl/spi_sck_gen.sv
// SPI mode-0 SCK divider: half-period of CLK_DIV clk cycles, with edge strobes.
// stall only blocks a rising edge, so a pending fall always completes and SCK parks low.
module spi_sck_gen #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic stall,
  output logic sck,
  output logic rise_tick,
  output logic fall_tick
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sck_q, sck_d;
  logic             adv_c;

  assign adv_c = run && !(stall && !sck_q);
  assign sck   = sck_q;

  always_comb begin
    cnt_d     = cnt_q;
    sck_d     = sck_q;
    rise_tick = 1'b0;
    fall_tick = 1'b0;
    if (!run) begin
      cnt_d = '0;
      sck_d = 1'b0;
    end else if (adv_c) begin
      if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
        cnt_d     = '0;
        sck_d     = !sck_q;
        rise_tick = !sck_q;
        fall_tick = sck_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      sck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sck_q <= sck_d;
    end
  end

endmodule

// File: rtl/spi_flash_reader.sv
// SPI NOR flash block reader (mode 0) delivering bytes on a valid/ready stream.
// Define FLASH_FAST_READ_EN for FAST READ with an 8-clock dummy phase.
module spi_flash_reader
  import flash_reader_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned CS_HIGH = 4,
  parameter int unsigned LEN_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [23:0]      addr,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic             flash_csb,
  output logic             flash_clk,
  output logic             flash_io0,
  input  logic             flash_io1
);

  localparam int unsigned    BIT_W    = 5;
  localparam int unsigned    CS_W     = (CS_HIGH > 1) ? $clog2(CS_HIGH) : 1;
  localparam logic [LEN_W:0] FULL_LEN = {1'b1, {LEN_W{1'b0}}};

  state_e           state_q, state_d;
  logic [31:0]      tx_q, tx_d;
  logic [7:0]       sh_q, sh_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [LEN_W:0]   left_q, left_d;
  logic [CS_W-1:0]  cs_cnt_q, cs_cnt_d;
  logic             pend_q, pend_d;
  logic [7:0]       rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             csb_q, csb_d;

  logic sck, rise_tick, fall_tick;
  logic run_c, stall_c, buf_free_c;

  // A completed byte parked in sh_q (pend_q) or an exhausted count keeps SCK low.
  assign run_c      = (state_q != ST_IDLE) && (state_q != ST_END);
  assign stall_c    = pend_q || (left_q == '0);
  assign buf_free_c = !rd_valid_q || rd_ready;

  spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck (
    .clk      (clk),
    .reset    (reset),
    .run      (run_c),
    .stall    (stall_c),
    .sck      (sck),
    .rise_tick(rise_tick),
    .fall_tick(fall_tick)
  );

  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    sh_d       = sh_q;
    bit_cnt_d  = bit_cnt_q;
    left_d     = left_q;
    cs_cnt_d   = cs_cnt_q;
    pend_d     = pend_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_valid_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    csb_d      = csb_q;

    if (rd_valid_q && rd_ready) rd_valid_d = 1'b0;
    if (pend_q && buf_free_c) begin
      rd_data_d  = sh_q;
      rd_valid_d = 1'b1;
      pend_d     = 1'b0;
    end
    if (fall_tick) tx_d = {tx_q[30:0], 1'b0};

    case (state_q)
      ST_IDLE: begin
        if (start && !done_q) begin
          tx_d      = {OPCODE, addr};
          left_d    = (len == '0) ? FULL_LEN : {1'b0, len};
          bit_cnt_d = '0;
          csb_d     = 1'b0;
          busy_d    = 1'b1;
          state_d   = ST_CMD;
        end
      end
      ST_CMD: begin
        if (rise_tick) begin
          if (bit_cnt_q == BIT_W'(CMD_BITS - 1)) begin
            bit_cnt_d = '0;
            state_d   = ST_ADDR;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end
      ST_ADDR: begin
        if (rise_tick) begin
          if (bit_cnt_q == BIT_W'(ADDR_BITS - 1)) begin
            bit_cnt_d = '0;
`ifdef FLASH_FAST_READ_EN
            state_d   = ST_DUMMY;
`else
            state_d   = ST_DATA;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end
`ifdef FLASH_FAST_READ_EN
      ST_DUMMY: begin
        if (rise_tick) begin
          if (bit_cnt_q == BIT_W'(DUMMY_BITS - 1)) begin
            bit_cnt_d = '0;
            state_d   = ST_DATA;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end
`endif
      ST_DATA: begin
        if (rise_tick) begin
          sh_d = {sh_q[6:0], flash_io1};
          if (bit_cnt_q[2:0] == 3'd7) begin
            bit_cnt_d = '0;
            left_d    = left_q - (LEN_W+1)'(1);
            if (buf_free_c) begin
              rd_data_d  = sh_d;
              rd_valid_d = 1'b1;
            end else begin
              pend_d = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end else if ((left_q == '0) && !pend_q && buf_free_c && !sck) begin
          csb_d    = 1'b1;
          cs_cnt_d = '0;
          state_d  = ST_END;
        end
      end
      ST_END: begin
        if (cs_cnt_q == CS_W'(CS_HIGH - 1)) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          cs_cnt_d = cs_cnt_q + CS_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      tx_q       <= '0;
      sh_q       <= '0;
      bit_cnt_q  <= '0;
      left_q     <= '0;
      cs_cnt_q   <= '0;
      pend_q     <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      csb_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      sh_q       <= sh_d;
      bit_cnt_q  <= bit_cnt_d;
      left_q     <= left_d;
      cs_cnt_q   <= cs_cnt_d;
      pend_q     <= pend_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      csb_q      <= csb_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign flash_csb = csb_q;
  assign flash_clk = sck;
  assign flash_io0 = tx_q[31];

endmodule
